tlc_fsm: RTL and testbench

Main traffic-light sequencer for the intersection controller. Consumes the synchronized `sensor_sync`, `wr_sync` and `prog_sync` signals from the synchronizer stage and a one-cycle `tick_1hz` enable from the divider. It steps the main-street, side-street and walk lamps through a timed state sequence. It holds three run-time programmable durations and latches pedestrian walk requests until they are served.

---
 rtl/tlc_pkg.sv | 46 ++++
 rtl/tlc_if.sv | 26 ++
 rtl/tlc_timer.sv | 52 +++++
 rtl/tlc_fsm.sv | 192 +++++++++++++++++++
 tb/tb_tlc_fsm.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types and constants for the intersection light sequencer.
// State codes double as the debug state output.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN     = 3'd0,
    MAIN_GRN2    = 3'd1,
    MAIN_YEL     = 3'd2,
    WALK         = 3'd3,
    SIDE_GRN     = 3'd4,
    SIDE_GRN_EXT = 3'd5,
    SIDE_YEL     = 3'd6
  } tlc_state_e;

  typedef enum logic [1:0] {
    SEL_BASE = 2'd0,
    SEL_EXT  = 2'd1,
    SEL_YEL  = 2'd2,
    SEL_NONE = 2'd3
  } tlc_sel_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } tlc_lamps_t;

  // Lamp pattern for a state; unknown codes fall back to all-red.
  function automatic tlc_lamps_t lamps_of(input tlc_state_e st);
    tlc_lamps_t l;
    case (st)
      MAIN_GRN, MAIN_GRN2:    l = {GRN, RED, 1'b0};
      MAIN_YEL:               l = {YEL, RED, 1'b0};
      WALK:                   l = {RED, RED, 1'b1};
      SIDE_GRN, SIDE_GRN_EXT: l = {RED, GRN, 1'b0};
      SIDE_YEL:               l = {RED, YEL, 1'b0};
      default:                l = {RED, RED, 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_if.sv
// tlc_if: control inputs and lamp outputs of the light sequencer.
// The master side drives ticks, sensors and programming; the slave is the FSM.
interface tlc_if #(
  parameter int CNT_W = 4
);
  logic             tick_1hz;
  logic             sensor_sync;
  logic             wr_sync;
  logic             prog_sync;
  logic [1:0]       time_sel;
  logic [CNT_W-1:0] time_val;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             walk_lamp;
  logic [2:0]       state_dbg;

  modport master (
    output tick_1hz, sensor_sync, wr_sync, prog_sync, time_sel, time_val,
    input  main_light, side_light, walk_lamp, state_dbg
  );

  modport slave (
    input  tick_1hz, sensor_sync, wr_sync, prog_sync, time_sel, time_val,
    output main_light, side_light, walk_lamp, state_dbg
  );
endinterface

// File: rtl/tlc_timer.sv
// tlc_timer: loadable down-counter that flags the expiring tick of a state.
// A load of zero is promoted to one so every state lasts at least one tick.
module tlc_timer #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expired
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] promote_zero(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b0}}) begin
      r = ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;

  assign expired = tick && (count_r == ONE);

  // Next count: a load overrides the decrement of an expiring tick
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = promote_zero(load_val);
    end else if (tick) begin
      count_next_s = count_r - ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= promote_zero(RST_VAL);
    end else begin
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/tlc_fsm.sv
// tlc_fsm: main traffic-light sequencer with run-time programmable durations.
// Build option TLC_WALK_EN adds the latched pedestrian request and WALK phase.
module tlc_fsm
  import tlc_pkg::*;
#(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int CNT_W  = 4
) (
  input logic  clk,
  input logic  reset,
  tlc_if.slave bus
);
  localparam logic [CNT_W-1:0] BASE_RST  = CNT_W'(T_BASE);
  localparam logic [CNT_W-1:0] EXT_RST   = CNT_W'(T_EXT);
  localparam logic [CNT_W-1:0] YEL_RST   = CNT_W'(T_YEL);
  localparam tlc_lamps_t       LAMPS_RST = {GRN, RED, 1'b0};

  tlc_state_e       state_r;
  tlc_state_e       state_next_s;
  tlc_sel_e         sel_s;
  logic [CNT_W-1:0] base_r;
  logic [CNT_W-1:0] ext_r;
  logic [CNT_W-1:0] yel_r;
  logic [CNT_W-1:0] base_new_s;
  logic [CNT_W-1:0] load_val_s;
  logic             load_s;
  logic             expired_s;
  logic             walk_req_s;
  tlc_lamps_t       lamps_r;
  tlc_lamps_t       lamps_next_s;

  assign sel_s = tlc_sel_e'(bus.time_sel);

  // Base duration a reprogram lands on, including a same-cycle base write
  always_comb begin
    base_new_s = base_r;
    if (bus.prog_sync && (sel_s == SEL_BASE)) begin
      base_new_s = bus.time_val;
    end else begin
      base_new_s = base_r;
    end
  end

  // Programmable duration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_r <= BASE_RST;
      ext_r  <= EXT_RST;
      yel_r  <= YEL_RST;
    end else if (bus.prog_sync) begin
      case (sel_s)
        SEL_BASE: base_r <= bus.time_val;
        SEL_EXT:  ext_r  <= bus.time_val;
        SEL_YEL:  yel_r  <= bus.time_val;
        default:  base_r <= base_r;
      endcase
    end else begin
      base_r <= base_r;
    end
  end

  tlc_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(BASE_RST)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .load_val(load_val_s),
    .tick    (bus.tick_1hz),
    .expired (expired_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= MAIN_GRN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and timer reload; reprogram outranks an expiring tick
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    load_val_s   = base_r;
    if (bus.prog_sync) begin
      state_next_s = MAIN_GRN;
      load_s       = 1'b1;
      load_val_s   = base_new_s;
    end else if (expired_s) begin
      load_s = 1'b1;
      case (state_r)
        MAIN_GRN: begin
          state_next_s = MAIN_GRN2;
          load_val_s   = bus.sensor_sync ? ext_r : base_r;
        end
        MAIN_GRN2: begin
          state_next_s = MAIN_YEL;
          load_val_s   = yel_r;
        end
        MAIN_YEL: begin
          if (walk_req_s) begin
            state_next_s = WALK;
            load_val_s   = ext_r;
          end else begin
            state_next_s = SIDE_GRN;
            load_val_s   = base_r;
          end
        end
        WALK: begin
          state_next_s = SIDE_GRN;
          load_val_s   = base_r;
        end
        SIDE_GRN: begin
          if (bus.sensor_sync) begin
            state_next_s = SIDE_GRN_EXT;
            load_val_s   = ext_r;
          end else begin
            state_next_s = SIDE_YEL;
            load_val_s   = yel_r;
          end
        end
        SIDE_GRN_EXT: begin
          state_next_s = SIDE_YEL;
          load_val_s   = yel_r;
        end
        SIDE_YEL: begin
          state_next_s = MAIN_GRN;
          load_val_s   = base_r;
        end
        default: begin
          state_next_s = MAIN_GRN;
          load_val_s   = base_r;
        end
      endcase
    end else begin
      state_next_s = state_r;
      load_s       = 1'b0;
    end
  end

`ifdef TLC_WALK_EN
  logic walk_req_r;
  logic enter_walk_s;

  assign enter_walk_s = (state_next_s == WALK) && (state_r != WALK);

  // Pending walk request; a fresh press wins over any clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_req_r <= 1'b0;
    end else if (bus.wr_sync) begin
      walk_req_r <= 1'b1;
    end else if (bus.prog_sync || enter_walk_s) begin
      walk_req_r <= 1'b0;
    end else begin
      walk_req_r <= walk_req_r;
    end
  end

  assign walk_req_s = walk_req_r;
`else
  assign walk_req_s = 1'b0;
`endif

  // Lamp decode of the upcoming state, so the registered lamps track state_r
  always_comb begin
    lamps_next_s = lamps_of(state_next_s);
`ifndef TLC_WALK_EN
    lamps_next_s.walk = 1'b0;
`endif
  end

  // Registered lamp outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lamps_r <= LAMPS_RST;
    end else begin
      lamps_r <= lamps_next_s;
    end
  end

  assign bus.main_light = lamps_r.main;
  assign bus.side_light = lamps_r.side;
  assign bus.walk_lamp  = lamps_r.walk;
  assign bus.state_dbg  = state_r;

endmodule

// File: tb/tb_tlc_fsm.sv
// tb_tlc_fsm: scoreboard bench for the light sequencer; expected per-tick
// observations are queued from phase durations and compared before each tick.
module tb_tlc_fsm;
  import tlc_pkg::*;

  localparam int CNT_W = 4;
`ifdef TLC_WALK_EN
  localparam int WALK_D = 3;
`else
  localparam int WALK_D = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [9:0] exp_q[$];

  tlc_if #(.CNT_W(CNT_W)) bus ();

  tlc_fsm #(
    .T_BASE(6),
    .T_EXT (3),
    .T_YEL (2),
    .CNT_W (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] exp_vec(input logic [2:0] st);
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    m = 3'b100;
    s = 3'b100;
    w = 1'b0;
    case (st)
      MAIN_GRN, MAIN_GRN2:    m = 3'b001;
      MAIN_YEL:               m = 3'b010;
      WALK:                   w = 1'b1;
      SIDE_GRN, SIDE_GRN_EXT: s = 3'b001;
      SIDE_YEL:               s = 3'b010;
      default: begin
        m = 3'b000;
        s = 3'b000;
      end
    endcase
    return {st, m, s, w};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.state_dbg, bus.main_light, bus.side_light, bus.walk_lamp};
  endfunction

  task automatic push_phase(input logic [2:0] st, input int d);
    for (int i = 0; i < d; i++) exp_q.push_back(exp_vec(st));
  endtask

  // One lap: walk/ext phases only when their duration is nonzero
  task automatic push_lap(input int b, input int g2, input int y, input int w, input int sge);
    push_phase(MAIN_GRN, b);
    push_phase(MAIN_GRN2, g2);
    push_phase(MAIN_YEL, y);
    if (w > 0) push_phase(WALK, w);
    push_phase(SIDE_GRN, b);
    if (sge > 0) push_phase(SIDE_GRN_EXT, sge);
    push_phase(SIDE_YEL, y);
  endtask

  // Drain the queue: compare, then issue one tick with optional wr/prog
  task automatic run_q(input string name, input int wr_at, input int prog_at,
                       input logic [1:0] sel, input logic [3:0] val);
    int n;
    logic [9:0] e;
    logic [9:0] o;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s tick %0d: got %b expected %b", name, i, o, e);
      end
      bus.tick_1hz  = 1'b1;
      bus.wr_sync   = (i == wr_at);
      bus.prog_sync = (i == prog_at);
      bus.time_sel  = sel;
      bus.time_val  = val;
      @(negedge clk);
      bus.tick_1hz  = 1'b0;
      bus.wr_sync   = 1'b0;
      bus.prog_sync = 1'b0;
      bus.time_sel  = SEL_NONE;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    logic [9:0] o;
    bus.prog_sync = 1'b1;
    bus.time_sel  = sel;
    bus.time_val  = val;
    @(negedge clk);
    bus.prog_sync = 1'b0;
    bus.time_sel  = SEL_NONE;
    o = obs();
    checks++;
    if (o !== exp_vec(MAIN_GRN)) begin
      errors++;
      $display("FAIL prog_latency sel=%0d val=%0d: got %b expected %b", sel, val, o, exp_vec(MAIN_GRN));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] o;
    bus.tick_1hz = 1'b0; bus.sensor_sync = 1'b0; bus.wr_sync = 1'b0;
    bus.prog_sync = 1'b0; bus.time_sel = SEL_NONE; bus.time_val = 4'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.tick_1hz = 1'b1;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      o = obs();
      checks++;
      if (o !== exp_vec(MAIN_GRN)) begin
        errors++;
        $display("FAIL reset_hold %0d: got %b expected %b", i, o, exp_vec(MAIN_GRN));
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    push_lap(6, 6, 2, 0, 0);
    run_q("default_lap", -1, -1, SEL_NONE, 4'd0);
  endtask

  task automatic test_sensor();
    bus.sensor_sync = 1'b1;
    push_lap(6, 3, 2, 0, 3);
    run_q("sensor_lap", -1, -1, SEL_NONE, 4'd0);
    bus.sensor_sync = 1'b0;
  endtask

  task automatic test_walk();
    bus.wr_sync = 1'b1;
    @(negedge clk);
    bus.wr_sync = 1'b0;
    @(negedge clk);
    push_lap(6, 6, 2, WALK_D, 0);
    run_q("walk_lap", -1, -1, SEL_NONE, 4'd0);
    push_lap(6, 6, 2, 0, 0);
    run_q("after_walk_lap", -1, -1, SEL_NONE, 4'd0);
  endtask

  // Press again on the MAIN_YEL expiring tick: the request must survive entry
  task automatic test_walk_collide();
    bus.wr_sync = 1'b1;
    @(negedge clk);
    bus.wr_sync = 1'b0;
    @(negedge clk);
    push_lap(6, 6, 2, WALK_D, 0);
    run_q("walk_collide_lap", 13, -1, SEL_NONE, 4'd0);
    push_lap(6, 6, 2, WALK_D, 0);
    run_q("walk_kept_lap", -1, -1, SEL_NONE, 4'd0);
    push_lap(6, 6, 2, 0, 0);
    run_q("walk_cleared_lap", -1, -1, SEL_NONE, 4'd0);
  endtask

  task automatic test_prog_expiry();
    push_phase(MAIN_GRN, 6);
    push_phase(MAIN_GRN2, 6);
    run_q("prog_expiry", -1, 11, SEL_NONE, 4'd0);
    push_lap(6, 6, 2, 0, 0);
    run_q("after_prog_expiry_lap", -1, -1, SEL_NONE, 4'd0);
  endtask

  task automatic test_reprogram();
    push_lap(6, 6, 2, 0, 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    run_q("to_side_grn", -1, -1, SEL_NONE, 4'd0);
    prog(SEL_BASE, 4'd4);
    push_lap(4, 4, 2, 0, 0);
    run_q("base4_lap", -1, -1, SEL_NONE, 4'd0);
    prog(SEL_BASE, 4'd0);
    push_lap(1, 1, 2, 0, 0);
    run_q("base0_lap", -1, -1, SEL_NONE, 4'd0);
    prog(SEL_BASE, 4'd6);
    prog(SEL_YEL, 4'd3);
    push_lap(6, 6, 3, 0, 0);
    run_q("yel3_lap", -1, -1, SEL_NONE, 4'd0);
  endtask

  task automatic test_async_reset();
    logic [9:0] o;
    push_phase(MAIN_GRN, 6);
    push_phase(MAIN_GRN2, 6);
    push_phase(MAIN_YEL, 3);
    push_phase(SIDE_GRN, 6);
    push_phase(SIDE_YEL, 1);
    run_q("to_side_yel", -1, -1, SEL_NONE, 4'd0);
    #2;
    reset = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== exp_vec(MAIN_GRN)) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", o, exp_vec(MAIN_GRN));
    end
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    push_lap(6, 6, 2, 0, 0);
    push_phase(MAIN_GRN, 1);
    run_q("post_reset_lap", -1, -1, SEL_NONE, 4'd0);
  endtask

  initial begin
    test_reset();
    test_sensor();
    test_walk();
    test_walk_collide();
    test_prog_expiry();
    test_reprogram();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
